gpc_popcnt_seq: RTL and testbench

- Sequential population-count controller that time-shares one gpc117_4 counter.
- Accepts a DATA_W-bit word over a valid/ready handshake and feeds it to the counter 7 bits per cycle, lowest bits first.
- Accumulates the per-chunk counts into a running total and presents the final count over a valid/ready handshake.
- Used where a full compressor tree costs too much area and a multi-cycle popcount is acceptable.

---
 rtl/gpc_pkg.sv | 28 ++
 rtl/gpc117_4.sv | 20 ++
 rtl/gpc_popcnt_seq.sv | 163 ++++++++++++++++
 tb/tb_gpc_popcnt_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpc_pkg.sv
// Shared definitions for the generalized parallel counter (GPC) blocks:
// chunk width, FSM state encoding and a constant-foldable clog2 helper.
package gpc_pkg;

  // Number of input bits a gpc117_4 counts in one pass (its src0 column).
  localparam int GPC_CHUNK_W = 7;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gpc_state_e;

  // Ceiling log2, usable in parameter expressions. clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result++;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpc117_4.sv
// (1,1,7;4) generalized parallel counter: seven weight-1 inputs, one
// weight-2 input and one weight-4 input summed into a 4-bit result.
// Maximum value is 7 + 2 + 4 = 13, so the output never overflows.
module gpc117_4 (
  input  logic [6:0] src0,
  input  logic       src1,
  input  logic       src2,
  output logic [3:0] dst
);

  // Weighted sum: the single-bit columns are placed at their binary weights,
  // then each weight-1 bit is added in.
  always_comb begin
    dst = {1'b0, src2, src1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      dst = dst + {3'b000, src0[i]};
    end
  end

endmodule

// File: rtl/gpc_popcnt_seq.sv
// Sequential population counter that time-shares a single gpc117_4.
// A DATA_W-bit word is taken over a valid/ready handshake, counted seven
// bits per cycle (lowest chunk first) and the total is returned over a
// second valid/ready handshake. A finished result and the next word can be
// exchanged in the same edge, so back-to-back words see no bubble.
//
// Optional build macro GPC_POPCNT_THRESH_EN adds a threshold input, sampled
// together with the word, and a registered out_ge flag (count >= thresh).
module gpc_popcnt_seq
  import gpc_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int CNT_W  = clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
`ifdef GPC_POPCNT_THRESH_EN
  input  logic [CNT_W-1:0]  thresh,
  output logic              out_ge,
`endif
  output logic              busy
);

  // Number of 7-bit chunks needed to cover the word; the shift register is
  // padded with zeros up to a whole number of chunks.
  localparam int NCHUNK = (DATA_W + GPC_CHUNK_W - 1) / GPC_CHUNK_W;
  localparam int SR_W   = NCHUNK * GPC_CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  gpc_state_e        state;
  gpc_state_e        state_next;
  logic [SR_W-1:0]   shift_q;
  logic [CNT_W-1:0]  acc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              finish;
  logic [3:0]        chunk_dst;
  logic              chunk_dst_unused;
  logic [CNT_W-1:0]  chunk_sum;

`ifdef GPC_POPCNT_THRESH_EN
  logic [CNT_W-1:0]  thresh_q;
  logic              ge_q;
`endif

  // The shared counter only ever sees the lowest chunk of the shift
  // register; the weight-2 and weight-4 columns are not needed here.
  gpc117_4 u_gpc (
    .src0 (shift_q[GPC_CHUNK_W-1:0]),
    .src1 (1'b0),
    .src2 (1'b0),
    .dst  (chunk_dst)
  );

  // With src1/src2 tied low the counter tops out at 7, so bit 3 stays zero.
  assign chunk_dst_unused = chunk_dst[3];

  // Running total including the chunk currently being counted. The total
  // can never exceed DATA_W, which always fits in CNT_W bits.
  assign chunk_sum = acc_q + CNT_W'(chunk_dst[2:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs. in_ready depends on out_ready
  // only in DONE, which is what allows the same-edge hand-off.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: load the word on accept, then shift one chunk per RUN cycle
  // while accumulating; the final sum is captured on the last chunk and
  // held until the next word finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      shift_q <= SR_W'(in_data);
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state == ST_RUN) begin
      shift_q <= shift_q >> GPC_CHUNK_W;
      acc_q   <= chunk_sum;
      idx_q   <= idx_q + IDX_W'(1);
      if (finish) begin
        count_q <= chunk_sum;
      end
    end
  end

  assign out_count = count_q;

`ifdef GPC_POPCNT_THRESH_EN
  // Threshold is captured with the word and compared against the final
  // sum in the same edge that loads out_count, so both stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      ge_q     <= 1'b0;
    end else if (accept) begin
      thresh_q <= thresh;
    end else if (finish) begin
      ge_q <= (chunk_sum >= thresh_q);
    end
  end

  assign out_ge = ge_q;
`endif

endmodule

// File: tb/tb_gpc_popcnt_seq.sv
// Self-checking bench for gpc_popcnt_seq. Stimulus pushes hand-computed
// results into scoreboard queues; independent monitors pop and compare
// whenever a result handshake happens. A 64-bit and a 5-bit instance run
// from the same clock and reset. Define GPC_POPCNT_THRESH_EN to include
// the threshold checks.
module tb_gpc_popcnt_seq;

  typedef struct {
    logic [6:0] count;
    logic       ge;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        busy;
  logic [6:0]  thresh;
  logic        out_ge;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [2:0]  b_out_count;
  logic        b_busy;
  logic [2:0]  b_thresh;
  logic        b_out_ge;

  exp_t        exp_q[$];
  logic [2:0]  b_exp_q[$];
  exp_t        mon_e;
  logic [2:0]  b_mon_e;

  int tests_run = 0;
  int failures  = 0;

  gpc_popcnt_seq #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
`ifdef GPC_POPCNT_THRESH_EN
    .thresh    (thresh),
    .out_ge    (out_ge),
`endif
    .busy      (busy)
  );

  gpc_popcnt_seq #(.DATA_W(5)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_count (b_out_count),
`ifdef GPC_POPCNT_THRESH_EN
    .thresh    (b_thresh),
    .out_ge    (b_out_ge),
`endif
    .busy      (b_busy)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor for the 64-bit instance: one comparison per result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL unexpected_result: got count %0d, expected no result", out_count);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("result_count", 64'(out_count), 64'(mon_e.count));
`ifdef GPC_POPCNT_THRESH_EN
        check_output("result_ge", 64'(out_ge), 64'(mon_e.ge));
`endif
      end
    end
  end

  // Monitor for the 5-bit instance.
  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL small_unexpected_result: got count %0d, expected no result", b_out_count);
      end else begin
        b_mon_e = b_exp_q.pop_front();
        check_output("small_result_count", 64'(b_out_count), 64'(b_mon_e));
      end
    end
  end

  // Offer one word to the 64-bit instance; returns #1 after the accept edge.
  task automatic apply_stimulus(input logic [63:0] data, input logic [6:0] exp_count,
                                input logic [6:0] th, input logic exp_ge,
                                input bit push_exp);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready %0b after %0d cycles, expected 1", in_ready, waited);
    end
    in_valid = 1'b1;
    in_data  = data;
    thresh   = th;
    if (push_exp) exp_q.push_back('{exp_count, exp_ge});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid rises.
  task automatic wait_result(input int exp_latency, input string name);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output(name, 64'(cycles), 64'(exp_latency));
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    thresh      = '0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b1;
    b_thresh    = '0;

    // Reset for three cycles, then check idle outputs.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_out_count", 64'(out_count), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("small_reset_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic counts: all ones, all zeros, top and bottom bit only.
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 7'd0, 1'b1, 1'b1);
    check_output("run_busy", 64'(busy), 64'd1);
    check_output("run_in_ready", 64'(in_ready), 64'd0);
    wait_result(10, "latency_all_ones");
    @(posedge clk);
    #1;
    check_output("idle_after_result", 64'(out_valid), 64'd0);

    apply_stimulus(64'h0, 7'd0, 7'd0, 1'b1, 1'b1);
    wait_result(10, "latency_zero");
    @(posedge clk);
    #1;

    apply_stimulus(64'h8000_0000_0000_0001, 7'd2, 7'd0, 1'b1, 1'b1);
    wait_result(10, "latency_edges");
    @(posedge clk);
    #1;

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    apply_stimulus(64'h0000_0000_FFFF_0000, 7'd16, 7'd0, 1'b1, 1'b1);
    wait_result(10, "latency_backpressure");
    for (int i = 0; i < 5; i++) begin
      check_output("hold_out_valid", 64'(out_valid), 64'd1);
      check_output("hold_out_count", 64'(out_count), 64'd16);
      check_output("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end

    // Back-to-back: release the result and offer a new word in one edge.
    in_valid  = 1'b1;
    in_data   = 64'h0F0F_0F0F_0F0F_0F0F;
    out_ready = 1'b1;
    exp_q.push_back('{7'd32, 1'b1});
    #1;
    check_output("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("b2b_busy", 64'(busy), 64'd1);
    check_output("b2b_out_valid", 64'(out_valid), 64'd0);
    wait_result(10, "latency_b2b");
    @(posedge clk);
    #1;

    // Reset during RUN discards the word.
    apply_stimulus(64'hFF, 7'd8, 7'd0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_in_ready", 64'(in_ready), 64'd1);
    check_output("midreset_out_valid", 64'(out_valid), 64'd0);
    check_output("midreset_out_count", 64'(out_count), 64'd0);
    check_output("midreset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_reset_out_valid", 64'(out_valid), 64'd0);
    apply_stimulus(64'h3, 7'd2, 7'd0, 1'b1, 1'b1);
    wait_result(10, "latency_after_reset");
    @(posedge clk);
    #1;

`ifdef GPC_POPCNT_THRESH_EN
    // Threshold flag on both sides of the boundary.
    apply_stimulus(64'hFF, 7'd8, 7'd8, 1'b1, 1'b1);
    wait_result(10, "latency_thresh_eq");
    @(posedge clk);
    #1;
    apply_stimulus(64'hFF, 7'd8, 7'd9, 1'b0, 1'b1);
    wait_result(10, "latency_thresh_above");
    @(posedge clk);
    #1;
`endif

    // Narrow instance: a single chunk, so RUN lasts one cycle.
    b_in_valid = 1'b1;
    b_in_data  = 5'b10110;
    b_exp_q.push_back(3'd3);
    check_output("small_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check_output("small_busy", 64'(b_busy), 64'd1);
    check_output("small_out_valid_run", 64'(b_out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_output("small_out_valid_done", 64'(b_out_valid), 64'd1);
    check_output("small_out_count", 64'(b_out_count), 64'd3);
    @(posedge clk);
    #1;
    check_output("small_out_valid_after", 64'(b_out_valid), 64'd0);

    // Every queued result must have been seen.
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check_output("small_scoreboard_drained", 64'(b_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
